grid_renderer: RTL and testbench

Parametrised cell-grid renderer for the Game of Life display path. It sits between `sync_pulse_generator` and the VGA pins in the `pixel_clock` domain. It tracks the raster position from the blank strobes and fetches the cell state for each pixel from a synchronous 1-bit cell memory. It then drives alive, dead or background colour with a fixed pipeline latency.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/grid_renderer_cell_scan_counter.sv | 54 +++++
 rtl/grid_renderer.sv | 227 ++++++++++++++++++++++
 tb/tb_grid_renderer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared display-path types and constants: 640x480 raster timing, default cell grid, grid colour.
// Optional gridline rendering in grid_renderer is enabled by defining GRID_RENDERER_GRIDLINES_EN.
package vga_pkg;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FRONT_640  = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BACK_640   = 48;
  localparam int H_TOTAL_640  = H_ACTIVE_640 + H_FRONT_640 + H_SYNC_640 + H_BACK_640;

  localparam int V_ACTIVE_480 = 480;
  localparam int V_FRONT_480  = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BACK_480   = 33;
  localparam int V_TOTAL_480  = V_ACTIVE_480 + V_FRONT_480 + V_SYNC_480 + V_BACK_480;

  localparam int DEF_GRID_COLS = 20;
  localparam int DEF_GRID_ROWS = 20;
  localparam int DEF_CELL_W    = 32;
  localparam int DEF_CELL_H    = 24;
  localparam int DEF_COLOR_W   = 4;

  // Gridline level, replicated on every channel.
  localparam int GRID_LEVEL = 4;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grid_renderer_cell_scan_counter.sv
// One axis of the cell scan: sub-cell position, cell index and in-range flag.
// The index saturates on the last cell so downstream addresses stay inside the grid.
module cell_scan_counter
  import vga_pkg::*;
#(
  parameter  int CELL_SIZE = DEF_CELL_W,
  parameter  int CELLS     = DEF_GRID_COLS,
  localparam int SUB_W     = ctr_width(CELL_SIZE),
  localparam int IDX_W     = ctr_width(CELLS)
) (
  input  logic             pixel_clock,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             clear,
  output logic [SUB_W-1:0] sub_count,
  output logic [IDX_W-1:0] cell_index,
  output logic             wrap,
  output logic             in_range
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

  logic sub_last;

  assign sub_last = (sub_count == SUB_LAST);

  // Pulses only when the cell index really steps, never on the final saturating wrap.
  assign wrap = advance & in_range & sub_last & (cell_index != IDX_LAST);

  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      sub_count  <= '0;
      cell_index <= '0;
      in_range   <= 1'b1;
    end else if (clear) begin
      sub_count  <= '0;
      cell_index <= '0;
      in_range   <= 1'b1;
    end else if (advance && in_range) begin
      if (sub_last) begin
        sub_count <= '0;
        if (cell_index == IDX_LAST) begin
          in_range <= 1'b0;
        end else begin
          cell_index <= cell_index + 1'b1;
        end
      end else begin
        sub_count <= sub_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_renderer.sv
// Cell-grid renderer: raster tracking from blank strobes, cell fetch, 2-cycle colour pipeline.
// Define GRID_RENDERER_GRIDLINES_EN to draw the first pixel row/column of every cell in grid colour.
module grid_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_640,
  parameter int V_ACTIVE  = V_ACTIVE_480,
  parameter int GRID_COLS = DEF_GRID_COLS,
  parameter int GRID_ROWS = DEF_GRID_ROWS,
  parameter int CELL_W    = DEF_CELL_W,
  parameter int CELL_H    = DEF_CELL_H,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int ADDR_W    = $clog2(GRID_COLS * GRID_ROWS)
) (
  input  logic                 pixel_clock,
  input  logic                 rst_n,
  input  logic                 i_hblank_n,
  input  logic                 i_vblank_n,
  input  logic [3*COLOR_W-1:0] i_alive_rgb,
  input  logic [3*COLOR_W-1:0] i_dead_rgb,
  output logic [ADDR_W-1:0]    o_cell_addr,
  output logic                 o_cell_rd_en,
  input  logic                 i_cell_data,
  output logic [COLOR_W-1:0]   o_vga_r,
  output logic [COLOR_W-1:0]   o_vga_g,
  output logic [COLOR_W-1:0]   o_vga_b,
  output logic                 o_frame_done
);

  localparam logic [0:0] WAIT_FRAME = 1'b0;
  localparam logic [0:0] ACTIVE     = 1'b1;

  localparam int PX_W = ctr_width(H_ACTIVE + 1);
  localparam int PY_W = ctr_width(V_ACTIVE + 1);
  localparam int SX_W = ctr_width(CELL_W);
  localparam int CX_W = ctr_width(GRID_COLS);
  localparam int SY_W = ctr_width(CELL_H);
  localparam int CY_W = ctr_width(GRID_ROWS);

  localparam logic [PX_W-1:0]   PX_LIMIT = PX_W'(H_ACTIVE);
  localparam logic [PY_W-1:0]   PY_LIMIT = PY_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(GRID_COLS);

  logic              hblank_q_reg;
  logic              vblank_q_reg;
  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic [PX_W-1:0]   px_reg;
  logic [PY_W-1:0]   py_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic              frame_done_reg;

  logic h_fall;
  logic v_fall;
  logic active;
  logic visible;
  logic in_screen;
  logic in_grid;
  logic x_clear;
  logic y_clear;
  logic y_advance;

  logic [SX_W-1:0] sx;
  logic [CX_W-1:0] cx;
  logic            x_wrap;
  logic            x_in_range;
  logic [SY_W-1:0] sy;
  logic [CY_W-1:0] cy;
  logic            y_wrap;
  logic            y_in_range;

  logic                 s1_visible_reg;
  logic                 s1_in_grid_reg;
  logic [3*COLOR_W-1:0] s1_rgb;

  // Edges are detected against registered copies; the blanks never clock anything.
  assign h_fall  = hblank_q_reg & ~i_hblank_n;
  assign v_fall  = vblank_q_reg & ~i_vblank_n;
  assign active  = (state_reg == ACTIVE);
  assign visible = active & i_hblank_n & i_vblank_n;

  assign x_clear   = ~active | h_fall | v_fall;
  assign y_clear   = ~active | v_fall;
  assign y_advance = h_fall & i_vblank_n;

  always_comb begin
    state_next = state_reg;
    if (state_reg == WAIT_FRAME && v_fall) begin
      state_next = ACTIVE;
    end
  end

  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      hblank_q_reg   <= 1'b0;
      vblank_q_reg   <= 1'b0;
      state_reg      <= WAIT_FRAME;
      px_reg         <= '0;
      py_reg         <= '0;
      row_base_reg   <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      hblank_q_reg   <= i_hblank_n;
      vblank_q_reg   <= i_vblank_n;
      state_reg      <= state_next;
      frame_done_reg <= active & v_fall;

      if (x_clear) begin
        px_reg <= '0;
      end else if (visible && px_reg != '1) begin
        px_reg <= px_reg + 1'b1;
      end

      if (y_clear) begin
        py_reg <= '0;
      end else if (y_advance && py_reg != '1) begin
        py_reg <= py_reg + 1'b1;
      end

      if (y_clear) begin
        row_base_reg <= '0;
      end else if (y_wrap) begin
        row_base_reg <= row_base_reg + ROW_STEP;
      end
    end
  end

  cell_scan_counter #(
    .CELL_SIZE (CELL_W),
    .CELLS     (GRID_COLS)
  ) u_x_scan (
    .pixel_clock (pixel_clock),
    .rst_n       (rst_n),
    .advance     (visible),
    .clear       (x_clear),
    .sub_count   (sx),
    .cell_index  (cx),
    .wrap        (x_wrap),
    .in_range    (x_in_range)
  );

  cell_scan_counter #(
    .CELL_SIZE (CELL_H),
    .CELLS     (GRID_ROWS)
  ) u_y_scan (
    .pixel_clock (pixel_clock),
    .rst_n       (rst_n),
    .advance     (y_advance),
    .clear       (y_clear),
    .sub_count   (sy),
    .cell_index  (cy),
    .wrap        (y_wrap),
    .in_range    (y_in_range)
  );

  // Scan counters mark the grid edge; px/py clip a grid that is larger than the screen.
  assign in_screen = (px_reg < PX_LIMIT) & (py_reg < PY_LIMIT);
  assign in_grid   = x_in_range & y_in_range & in_screen;

  assign o_cell_addr  = row_base_reg + ADDR_W'(cx);
  assign o_cell_rd_en = visible & in_grid;
  assign o_frame_done = frame_done_reg;

  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_visible_reg <= 1'b0;
      s1_in_grid_reg <= 1'b0;
    end else begin
      s1_visible_reg <= visible;
      s1_in_grid_reg <= in_grid;
    end
  end

`ifdef GRID_RENDERER_GRIDLINES_EN
  localparam logic [COLOR_W-1:0] GRID_COLOR = COLOR_W'(GRID_LEVEL);

  logic s1_grid_line_reg;
  logic unused_scan;

  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_grid_line_reg <= 1'b0;
    end else begin
      s1_grid_line_reg <= (sx == '0) | (sy == '0);
    end
  end

  assign unused_scan = ^{x_wrap, cy};
`else
  logic unused_scan;

  assign unused_scan = ^{x_wrap, cy, sx, sy};
`endif

  always_comb begin
    s1_rgb = i_cell_data ? i_alive_rgb : i_dead_rgb;
    if (!s1_in_grid_reg) begin
      s1_rgb = '0;
    end
`ifdef GRID_RENDERER_GRIDLINES_EN
    else if (s1_grid_line_reg) begin
      s1_rgb = {3{GRID_COLOR}};
    end
`endif
  end

  // Channel 0 is red, taken from the top of the packed {R,G,B} word.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [COLOR_W-1:0] level_reg;

      always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
          level_reg <= '0;
        end else begin
          level_reg <= s1_visible_reg ? s1_rgb[(2-gi)*COLOR_W +: COLOR_W] : '0;
        end
      end
    end
  endgenerate

  assign o_vga_r = g_chan[0].level_reg;
  assign o_vga_g = g_chan[1].level_reg;
  assign o_vga_b = g_chan[2].level_reg;

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: default 20x20 grid plus a 16-column instance on shared strobes.
module tb_grid_renderer;

  logic        pixel_clock = 1'b0;
  logic        rst_n       = 1'b0;
  logic        hblank_n    = 1'b0;
  logic        vblank_n    = 1'b0;
  logic [11:0] alive_rgb   = 12'hF00;
  logic [11:0] dead_rgb    = 12'h00F;

  logic [8:0] addr_a, addr_b;
  logic       rd_a, rd_b;
  logic       data_a = 1'b0;
  logic       data_b = 1'b0;
  logic [3:0] ra, ga, ba, rb, gb, bb;
  logic       fd_a, fd_b;

  grid_renderer u_dut (
    .pixel_clock  (pixel_clock),
    .rst_n        (rst_n),
    .i_hblank_n   (hblank_n),
    .i_vblank_n   (vblank_n),
    .i_alive_rgb  (alive_rgb),
    .i_dead_rgb   (dead_rgb),
    .o_cell_addr  (addr_a),
    .o_cell_rd_en (rd_a),
    .i_cell_data  (data_a),
    .o_vga_r      (ra),
    .o_vga_g      (ga),
    .o_vga_b      (ba),
    .o_frame_done (fd_a)
  );

  grid_renderer #(.GRID_COLS(16)) u_dut16 (
    .pixel_clock  (pixel_clock),
    .rst_n        (rst_n),
    .i_hblank_n   (hblank_n),
    .i_vblank_n   (vblank_n),
    .i_alive_rgb  (alive_rgb),
    .i_dead_rgb   (dead_rgb),
    .o_cell_addr  (addr_b),
    .o_cell_rd_en (rd_b),
    .i_cell_data  (data_b),
    .o_vga_r      (rb),
    .o_vga_g      (gb),
    .o_vga_b      (bb),
    .o_frame_done (fd_b)
  );

  always #5 pixel_clock = ~pixel_clock;

  logic cell_mem [400];

  always @(posedge pixel_clock) begin
    if (rd_a) data_a <= cell_mem[addr_a];
    if (rd_b) data_b <= cell_mem[addr_b];
  end

  logic [8:0]  rec_addr_a [int];
  logic [8:0]  rec_addr_b [int];
  logic        rec_rd_a   [int];
  logic        rec_rd_b   [int];
  logic [11:0] rec_rgb_a  [int];
  logic [11:0] rec_rgb_b  [int];
  logic        rec_fd_a   [int];
  int          pix_cyc    [int];

  int cyc    = 0;
  int cur_y  = 0;
  int checks = 0;
  int errors = 0;

  task automatic step(input logic h, input logic v);
    hblank_n = h;
    vblank_n = v;
    @(negedge pixel_clock);
    rec_addr_a[cyc] = addr_a;
    rec_addr_b[cyc] = addr_b;
    rec_rd_a[cyc]   = rd_a;
    rec_rd_b[cyc]   = rd_b;
    rec_rgb_a[cyc]  = {ra, ga, ba};
    rec_rgb_b[cyc]  = {rb, gb, bb};
    rec_fd_a[cyc]   = fd_a;
    @(posedge pixel_clock);
    #1;
    cyc++;
  endtask

  task automatic line(input int vis, input int blank);
    for (int x = 0; x < vis; x++) begin
      pix_cyc[cur_y*4096 + x] = cyc;
      step(1'b1, 1'b1);
    end
    for (int b = 0; b < blank; b++) step(1'b0, 1'b1);
    cur_y++;
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    cur_y = 0;
    pix_cyc.delete();
  endtask

  function automatic int pc(input int x, input int y);
    return pix_cyc[y*4096 + x];
  endfunction

  // Expected in-grid colour, with the gridline override when that build option is on.
  function automatic logic [11:0] expc(input int x, input int y, input logic [11:0] base);
`ifdef GRID_RENDERER_GRIDLINES_EN
    if ((x % 32) == 0 || (y % 24) == 0) return 12'h444;
`endif
    return base;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    checks++;
    if (rec_rgb_a[cyc-1] !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb: got %h expected 000", rec_rgb_a[cyc-1]);
    end
    checks++;
    if (rec_rd_a[cyc-1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_en: got %b expected 0", rec_rd_a[cyc-1]);
    end
    checks++;
    if (rec_addr_a[cyc-1] !== 9'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d expected 0", rec_addr_a[cyc-1]);
    end
    checks++;
    if (rec_fd_a[cyc-1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_done: got %b expected 0", rec_fd_a[cyc-1]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wait_frame();
    int c0;
    int bad;
    int fd_cnt;
    c0 = cyc;
    for (int l = 0; l < 3; l++) line(40, 4);
    bad = 0;
    for (int c = c0; c < cyc; c++)
      if (rec_rgb_a[c] !== 12'h000 || rec_rd_a[c] !== 1'b0 ||
          rec_rgb_b[c] !== 12'h000 || rec_rd_b[c] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wait_frame_black: got %0d active cycles expected 0", bad);
    end
    c0 = cyc;
    vblank(6);
    fd_cnt = 0;
    for (int c = c0; c < cyc; c++) if (rec_fd_a[c] === 1'b1) fd_cnt++;
    checks++;
    if (fd_cnt !== 0) begin
      errors++;
      $display("FAIL first_vblank_no_done: got %0d pulses expected 0", fd_cnt);
    end
  endtask

  task automatic test_checkerboard();
    int          vx   [12] = '{0, 31, 32, 63, 64, 31, 31, 32, 64, 64, 100, 1};
    int          vy   [12] = '{0, 0, 0, 0, 0, 23, 24, 24, 47, 48, 50, 1};
    int          vaddr[12] = '{0, 0, 1, 1, 2, 0, 20, 21, 22, 42, 43, 0};
    logic [11:0] vrgb [12] = '{12'hF00, 12'hF00, 12'h00F, 12'h00F, 12'hF00, 12'hF00,
                               12'h00F, 12'hF00, 12'h00F, 12'hF00, 12'h00F, 12'hF00};
    int          c;
    logic [11:0] want;
    for (int l = 0; l < 50; l++) line(110, 4);
    line(110, 0);
    for (int i = 0; i < 12; i++) begin
      c    = pc(vx[i], vy[i]);
      want = expc(vx[i], vy[i], vrgb[i]);
      checks++;
      if (rec_rd_a[c] !== 1'b1) begin
        errors++;
        $display("FAIL cb_rd_en x=%0d y=%0d: got %b expected 1", vx[i], vy[i], rec_rd_a[c]);
      end
      checks++;
      if (rec_addr_a[c] !== 9'(vaddr[i])) begin
        errors++;
        $display("FAIL cb_addr x=%0d y=%0d: got %0d expected %0d", vx[i], vy[i], rec_addr_a[c], vaddr[i]);
      end
      checks++;
      if (rec_rgb_a[c+2] !== want) begin
        errors++;
        $display("FAIL cb_rgb x=%0d y=%0d: got %h expected %h", vx[i], vy[i], rec_rgb_a[c+2], want);
      end
    end
  endtask

  task automatic test_frame_done();
    int c0;
    int fd_cnt;
    int c;
    c0 = cyc;
    vblank(8);
    fd_cnt = 0;
    for (int k = c0; k < cyc; k++) if (rec_fd_a[k] === 1'b1) fd_cnt++;
    checks++;
    if (fd_cnt !== 1) begin
      errors++;
      $display("FAIL frame_done_width: got %0d cycles expected 1", fd_cnt);
    end
    checks++;
    if (rec_fd_a[c0+1] !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_timing: got %b expected 1", rec_fd_a[c0+1]);
    end
    line(8, 4);
    c = pc(0, 0);
    checks++;
    if (rec_addr_a[c] !== 9'd0 || rec_rd_a[c] !== 1'b1) begin
      errors++;
      $display("FAIL next_frame_first_addr: got %0d/%b expected 0/1", rec_addr_a[c], rec_rd_a[c]);
    end
    checks++;
    if (rec_rgb_a[c+2] !== expc(0, 0, 12'hF00)) begin
      errors++;
      $display("FAIL next_frame_first_rgb: got %h expected %h", rec_rgb_a[c+2], expc(0, 0, 12'hF00));
    end
  endtask

  task automatic test_grid16();
    int c;
    line(650, 4);
    c = pc(511, 1);
    checks++;
    if (rec_addr_b[c] !== 9'd15 || rec_rd_b[c] !== 1'b1) begin
      errors++;
      $display("FAIL g16_last_in_grid: got %0d/%b expected 15/1", rec_addr_b[c], rec_rd_b[c]);
    end
    checks++;
    if (rec_rgb_b[c+2] !== 12'h00F) begin
      errors++;
      $display("FAIL g16_last_rgb: got %h expected 00f", rec_rgb_b[c+2]);
    end
    c = pc(512, 1);
    checks++;
    if (rec_rd_b[c] !== 1'b0) begin
      errors++;
      $display("FAIL g16_out_rd_en: got %b expected 0", rec_rd_b[c]);
    end
    checks++;
    if (rec_rgb_b[c+2] !== 12'h000) begin
      errors++;
      $display("FAIL g16_out_rgb: got %h expected 000", rec_rgb_b[c+2]);
    end
    c = pc(600, 1);
    checks++;
    if (rec_addr_b[c] !== 9'd15) begin
      errors++;
      $display("FAIL g16_addr_saturate: got %0d expected 15", rec_addr_b[c]);
    end
    c = pc(639, 1);
    checks++;
    if (rec_addr_a[c] !== 9'd19 || rec_rd_a[c] !== 1'b1) begin
      errors++;
      $display("FAIL g20_last_col: got %0d/%b expected 19/1", rec_addr_a[c], rec_rd_a[c]);
    end
    c = pc(645, 1);
    checks++;
    if (rec_addr_a[c] !== 9'd19 || rec_rd_a[c] !== 1'b0) begin
      errors++;
      $display("FAIL g20_beyond_screen: got %0d/%b expected 19/0", rec_addr_a[c], rec_rd_a[c]);
    end
    checks++;
    if (rec_rgb_a[c+2] !== 12'h000) begin
      errors++;
      $display("FAIL g20_beyond_rgb: got %h expected 000", rec_rgb_a[c+2]);
    end
  endtask

  task automatic test_row_boundary();
    int c;
    while (cur_y < 482) line(4, 2);
    c = pc(1, 479);
    checks++;
    if (rec_addr_a[c] !== 9'd380 || rec_rd_a[c] !== 1'b1) begin
      errors++;
      $display("FAIL last_row_addr: got %0d/%b expected 380/1", rec_addr_a[c], rec_rd_a[c]);
    end
    checks++;
    if (rec_rgb_a[c+2] !== expc(1, 479, 12'h00F)) begin
      errors++;
      $display("FAIL last_row_rgb: got %h expected %h", rec_rgb_a[c+2], expc(1, 479, 12'h00F));
    end
    checks++;
    if (rec_addr_b[c] !== 9'd304 || rec_rd_b[c] !== 1'b1) begin
      errors++;
      $display("FAIL g16_last_row_addr: got %0d/%b expected 304/1", rec_addr_b[c], rec_rd_b[c]);
    end
    c = pc(1, 480);
    checks++;
    if (rec_addr_a[c] !== 9'd380 || rec_rd_a[c] !== 1'b0) begin
      errors++;
      $display("FAIL below_grid: got %0d/%b expected 380/0", rec_addr_a[c], rec_rd_a[c]);
    end
    checks++;
    if (rec_rgb_a[c+2] !== 12'h000) begin
      errors++;
      $display("FAIL below_grid_rgb: got %h expected 000", rec_rgb_a[c+2]);
    end
  endtask

  task automatic test_reset_midframe();
    int c0;
    int bad;
    int fd_cnt;
    int c;
    vblank(4);
    line(70, 4);
    line(70, 4);
    for (int x = 0; x < 40; x++) begin
      pix_cyc[cur_y*4096 + x] = cyc;
      step(1'b1, 1'b1);
    end
    c = pc(37, 2);
    checks++;
    if (rec_rgb_a[c+2] !== expc(37, 2, 12'h00F)) begin
      errors++;
      $display("FAIL pre_reset_rgb: got %h expected %h", rec_rgb_a[c+2], expc(37, 2, 12'h00F));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ra, ga, ba} !== 12'h000 || rd_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h/%b expected 000/0", {ra, ga, ba}, rd_a);
    end
    c0 = cyc;
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    for (int x = 41; x < 70; x++) step(1'b1, 1'b1);
    for (int b = 0; b < 4; b++) step(1'b0, 1'b1);
    cur_y++;
    line(70, 4);
    line(70, 4);
    bad = 0;
    for (int k = c0; k < cyc; k++)
      if (rec_rgb_a[k] !== 12'h000 || rec_rd_a[k] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL post_reset_black: got %0d active cycles expected 0", bad);
    end
    c0 = cyc;
    vblank(4);
    fd_cnt = 0;
    for (int k = c0; k < cyc; k++) if (rec_fd_a[k] === 1'b1) fd_cnt++;
    checks++;
    if (fd_cnt !== 0) begin
      errors++;
      $display("FAIL post_reset_no_done: got %0d pulses expected 0", fd_cnt);
    end
    line(40, 4);
    c = pc(1, 0);
    checks++;
    if (rec_addr_a[c] !== 9'd0 || rec_rd_a[c] !== 1'b1) begin
      errors++;
      $display("FAIL restart_addr: got %0d/%b expected 0/1", rec_addr_a[c], rec_rd_a[c]);
    end
    checks++;
    if (rec_rgb_a[c+2] !== expc(1, 0, 12'hF00)) begin
      errors++;
      $display("FAIL restart_rgb: got %h expected %h", rec_rgb_a[c+2], expc(1, 0, 12'hF00));
    end
  endtask

  initial begin
    for (int i = 0; i < 400; i++) cell_mem[i] = (((i % 20) + (i / 20)) % 2) == 0;
    test_reset();
    test_wait_frame();
    test_checkerboard();
    test_frame_done();
    test_grid16();
    test_row_boundary();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
